multi_cycle_ctrl: RTL

//  Multi-cycle control unit. A Moore-style FSM walks each instruction through IF/ID/EXE/MEM/WB.
//  It drives the write enables of the PC, the instruction register (IRWre), the register file and

---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/mc_ctrl_decode.sv | 54 +++++
 rtl/multi_cycle_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states, datapath selects.
package mc_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned STATE_W = 4;

    // Opcodes (Instruction[31:26]); jr and halt get dedicated primary opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_JR    = 6'h3E;
    localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

    // FSM state encodings (visible on the debug state port)
    localparam logic [STATE_W-1:0] S_IF     = 4'd0;
    localparam logic [STATE_W-1:0] S_ID     = 4'd1;
    localparam logic [STATE_W-1:0] S_EXE_AL = 4'd2;
    localparam logic [STATE_W-1:0] S_WB_AL  = 4'd3;
    localparam logic [STATE_W-1:0] S_EXE_BR = 4'd4;
    localparam logic [STATE_W-1:0] S_EXE_LS = 4'd5;
    localparam logic [STATE_W-1:0] S_MEM    = 4'd6;
    localparam logic [STATE_W-1:0] S_WB_LD  = 4'd7;
    localparam logic [STATE_W-1:0] S_HALT   = 4'd8;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b100;

    // Next-PC source select
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_JMP = 2'b11;

    // Register-file destination select
    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

    // Instruction class, steers the ID-state dispatch
    typedef enum logic [2:0] {
        CLS_UNDEF = 3'd0,
        CLS_ALU   = 3'd1,
        CLS_BR    = 3'd2,
        CLS_LS    = 3'd3,
        CLS_JMP   = 3'd4,
        CLS_HALT  = 3'd5
    } op_class_e;

    // Opcode-derived datapath controls, constant for an instruction
    typedef struct packed {
        op_class_e            cls;
        logic [ALUOP_W-1:0]   alu_op;
        logic                 alu_src_b;
        logic                 ext_sel;
        logic [1:0]           reg_dst;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode decoder: instruction class plus the static ALU/operand/destination selects.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] opcode_i,
    output dec_t            dec_o
);

    // Pure opcode lookup; unknown opcodes fall out as CLS_UNDEF with all selects at zero
    always_comb begin
        dec_o           = '0;
        dec_o.cls       = CLS_UNDEF;
        dec_o.alu_op    = ALU_ADD;
        dec_o.reg_dst   = REGDST_RA;
        case (opcode_i)
            OP_RTYPE: begin
                dec_o.cls     = CLS_ALU;
                dec_o.reg_dst = REGDST_RD;
            end
            OP_ADDI: begin
                dec_o.cls       = CLS_ALU;
                dec_o.alu_src_b = 1'b1;
                dec_o.ext_sel   = 1'b1;
                dec_o.reg_dst   = REGDST_RT;
            end
            OP_ORI: begin
                dec_o.cls       = CLS_ALU;
                dec_o.alu_op    = ALU_OR;
                dec_o.alu_src_b = 1'b1;
                dec_o.reg_dst   = REGDST_RT;
            end
            OP_LW: begin
                dec_o.cls       = CLS_LS;
                dec_o.alu_src_b = 1'b1;
                dec_o.ext_sel   = 1'b1;
                dec_o.reg_dst   = REGDST_RT;
            end
            OP_SW: begin
                dec_o.cls       = CLS_LS;
                dec_o.alu_src_b = 1'b1;
                dec_o.ext_sel   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_o.cls     = CLS_BR;
                dec_o.alu_op  = ALU_SUB;
                dec_o.ext_sel = 1'b1;
            end
            OP_J, OP_JAL, OP_JR: dec_o.cls = CLS_JMP;
            OP_HALT:             dec_o.cls = CLS_HALT;
            default:             ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control unit: Moore FSM over IF/ID/EXE/MEM/WB driving all datapath enables and selects.
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [OP_W-1:0]      opcode,
    input  logic                 zero,
    output logic                 PCWre,
    output logic                 IRWre,
    output logic                 InsMemRW,
    output logic                 RegWre,
    output logic                 mRD,
    output logic                 mWR,
    output logic                 ALUSrcB,
    output logic                 ExtSel,
    output logic                 DBDataSrc,
    output logic [1:0]           RegDst,
    output logic                 WrRegDSrc,
    output logic [1:0]           PCSrc,
    output logic [ALUOP_W-1:0]   ALUOp,
    output logic [STATE_W-1:0]   state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    dec_t               dec;
    logic               is_lw;
    logic               is_sw;
    logic               is_jal;
    logic               br_taken;

    mc_ctrl_decode u_decode (
        .opcode_i (opcode),
        .dec_o    (dec)
    );

    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_jal   = (opcode == OP_JAL);
    assign br_taken = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
    assign state    = state_q;

    // State register; reset abandons any instruction in flight
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: dispatch on instruction class in ID, fixed walk elsewhere
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:     state_d = S_ID;
            S_ID: begin
                case (dec.cls)
                    CLS_ALU:  state_d = S_EXE_AL;
                    CLS_BR:   state_d = S_EXE_BR;
                    CLS_LS:   state_d = S_EXE_LS;
                    CLS_HALT: state_d = S_HALT;
                    default:  state_d = S_IF;
                endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    // Control outputs: opcode selects held all instruction, enables pulsed per state, all gated by reset
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b1;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcB   = dec.alu_src_b;
        ExtSel    = dec.ext_sel;
        DBDataSrc = is_lw;
        RegDst    = dec.reg_dst;
        WrRegDSrc = !is_jal;
        ALUOp     = dec.alu_op;
        PCSrc     = PCSRC_SEQ;
        if ((opcode == OP_J) || is_jal) begin
            PCSrc = PCSRC_JMP;
        end else if (opcode == OP_JR) begin
            PCSrc = PCSRC_JR;
        end

        case (state_q)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                if ((dec.cls == CLS_JMP) || (dec.cls == CLS_UNDEF)) begin
                    PCWre = 1'b1;
                end
                RegWre = is_jal;
            end
            S_WB_AL: begin
                PCWre  = 1'b1;
                RegWre = 1'b1;
            end
            S_EXE_BR: begin
                PCWre = 1'b1;
                if (br_taken) begin
                    PCSrc = PCSRC_BR;
                end
            end
            S_MEM: begin
                PCWre = is_sw;
                mWR   = is_sw;
                mRD   = is_lw;
            end
            S_WB_LD: begin
                PCWre  = 1'b1;
                RegWre = 1'b1;
                mRD    = 1'b1;
            end
            default: ;
        endcase

        if (!Reset) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            RegWre    = 1'b0;
            mRD       = 1'b0;
            mWR       = 1'b0;
            ALUSrcB   = 1'b0;
            ExtSel    = 1'b0;
            DBDataSrc = 1'b0;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
            PCSrc     = 2'b00;
            ALUOp     = '0;
        end
    end

endmodule
